// File: rtl/dkong_dma_pkg.sv
// Shared state encoding, default sizes and checksum helper for the
// Donkey Kong object-RAM DMA initiator.
package dkong_dma_pkg;

  localparam int DEF_SRC_AW = 10;
  localparam int DEF_DST_AW = 9;
  localparam int DEF_LEN_W  = 9;
  localparam int OBJ_LEN    = 384;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } dma_state_e;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/dkong_obj_dma.sv
// Object-RAM DMA initiator: copies a work-RAM block into the object buffer.
// Define DKONG_DMA_CHECKSUM_EN to get an XOR checksum of written bytes on O_CSUM.
module dkong_obj_dma
  import dkong_dma_pkg::*;
#(
  parameter int SRC_AW = DEF_SRC_AW,
  parameter int DST_AW = DEF_DST_AW,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_START,
  input  logic [SRC_AW-1:0] I_SRC_BASE,
  input  logic [DST_AW-1:0] I_DST_BASE,
  input  logic [LEN_W-1:0]  I_LEN,
  output logic              O_HOLD,
  input  logic              I_HLDA,
  output logic [SRC_AW-1:0] O_SRC_ADDR,
  output logic              O_SRC_CE,
  input  logic [7:0]        I_SRC_D,
  output logic [DST_AW-1:0] O_DST_ADDR,
  output logic [7:0]        O_DST_D,
  output logic              O_DST_CE,
  output logic              O_DST_WE,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [7:0]        O_CSUM
);

  dma_state_e        state_r, state_s;
  logic [SRC_AW-1:0] src_base_r, src_addr_r;
  logic [DST_AW-1:0] dst_base_r, dst_addr_r;
  logic [LEN_W-1:0]  len_r, idx_r, idx_s;
  logic              hold_r, busy_r, done_r, src_ce_r, dst_we_r;
  logic              start_ok_s, last_rd_s;

  assign start_ok_s = (state_r == S_IDLE) && I_START;
  // idx_r is the index being read while in XFER, otherwise the next unread one.
  assign last_rd_s  = (idx_r == (len_r - LEN_W'(1)));

  // Next-state and index sequencing.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (I_START) begin
          idx_s = '0;
          if (I_LEN != '0) state_s = S_REQ;
          else             state_s = S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (I_HLDA) state_s = S_XFER;
        else        state_s = S_REQ;
      end
      S_XFER: begin
        idx_s = idx_r + LEN_W'(1);
        if (last_rd_s)   state_s = S_DRAIN;
        else if (I_HLDA) state_s = S_XFER;
        else             state_s = S_REQ;
      end
      S_DRAIN: state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, latched transfer parameters and registered bus-side outputs.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      len_r      <= '0;
      src_base_r <= '0;
      dst_base_r <= '0;
      hold_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      src_ce_r   <= 1'b0;
      src_addr_r <= '0;
      dst_we_r   <= 1'b0;
      dst_addr_r <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (start_ok_s) begin
        src_base_r <= I_SRC_BASE;
        dst_base_r <= I_DST_BASE;
        len_r      <= I_LEN;
      end
      hold_r     <= (state_s == S_REQ) || (state_s == S_XFER) || (state_s == S_DRAIN);
      busy_r     <= (state_s != S_IDLE);
      done_r     <= (state_s == S_DONE);
      src_ce_r   <= (state_s == S_XFER);
      src_addr_r <= (state_s == S_XFER) ? (src_base_r + SRC_AW'(idx_s)) : '0;
      // Every issued read is written the following cycle, whatever HLDA does.
      dst_we_r   <= (state_r == S_XFER);
      dst_addr_r <= (state_r == S_XFER) ? (dst_base_r + DST_AW'(idx_r)) : '0;
    end
  end

  assign O_HOLD     = hold_r;
  assign O_BUSY     = busy_r;
  assign O_DONE     = done_r;
  assign O_SRC_CE   = src_ce_r;
  assign O_SRC_ADDR = src_addr_r;
  assign O_DST_CE   = dst_we_r;
  assign O_DST_WE   = dst_we_r;
  assign O_DST_ADDR = dst_addr_r;
  // The source RAM output register feeds the buffer directly so a byte lands one cycle after its read.
  assign O_DST_D    = dst_we_r ? I_SRC_D : 8'h00;

`ifdef DKONG_DMA_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR of written bytes, held from completion until the next start.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      csum_r <= 8'h00;
    end else if (start_ok_s) begin
      csum_r <= 8'h00;
    end else if (dst_we_r) begin
      csum_r <= csum_next(csum_r, I_SRC_D);
    end else begin
      csum_r <= csum_r;
    end
  end

  assign O_CSUM = csum_r;
`else
  assign O_CSUM = 8'h00;
`endif

endmodule

// File: tb/tb_dkong_obj_dma.sv
// Scoreboard bench for dkong_obj_dma: expected reads/writes are queued at launch
// and popped as the DUT issues them; a 1-cycle source RAM model feeds I_SRC_D.
`timescale 1ns/1ps
module tb_dkong_obj_dma;
  import dkong_dma_pkg::*;

  localparam int SAW = 10;
  localparam int DAW = 9;
  localparam int LW  = 9;
`ifdef DKONG_DMA_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, hlda = 1'b0;
  logic [SAW-1:0] src_base = '0, src_addr;
  logic [DAW-1:0] dst_base = '0, dst_addr;
  logic [LW-1:0]  len = '0;
  logic [7:0]     src_d = 8'h00, dst_d, csum;
  logic hold, src_ce, dst_ce, dst_we, busy, done;

  always #5 clk = ~clk;

  dkong_obj_dma #(.SRC_AW(SAW), .DST_AW(DAW), .LEN_W(LW)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start),
    .I_SRC_BASE(src_base), .I_DST_BASE(dst_base), .I_LEN(len),
    .O_HOLD(hold), .I_HLDA(hlda),
    .O_SRC_ADDR(src_addr), .O_SRC_CE(src_ce), .I_SRC_D(src_d),
    .O_DST_ADDR(dst_addr), .O_DST_D(dst_d), .O_DST_CE(dst_ce), .O_DST_WE(dst_we),
    .O_BUSY(busy), .O_DONE(done), .O_CSUM(csum)
  );

  logic [7:0] mem [0:1023];
  logic [SAW-1:0]   rd_q [$];
  logic [DAW+7:0]   wr_q [$];
  int   n_pass = 0, n_chk = 0, cyc = 0;
  int   rd_count, wr_count, first_rd, done_cyc, start_cyc;
  logic hlda_q = 1'b0, hold_seen, done_busy;
  logic [7:0] exp_csum, done_csum;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Source RAM: one-cycle synchronous read.
  always @(posedge clk) begin
    if (src_ce) src_d <= mem[src_addr];
    hlda_q <= hlda;
    cyc    <= cyc + 1;
  end

  // Output monitor: pop and compare every read and write the DUT issues.
  always @(negedge clk) begin
    logic [SAW-1:0] ea;
    logic [DAW+7:0] ew;
    if (src_ce) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
      chk("rd_after_hlda", hlda_q, 1'b1);
      if (rd_q.size() != 0) ea = rd_q.pop_front(); else ea = 'x;
      chk("rd_addr", src_addr, ea);
    end
    if (dst_we) begin
      wr_count++;
      chk("wr_ce", dst_ce, 1'b1);
      if (wr_q.size() != 0) ew = wr_q.pop_front(); else ew = 'x;
      chk("wr_addr", dst_addr, ew[DAW+7:8]);
      chk("wr_data", dst_d, ew[7:0]);
    end
    if (hold) hold_seen = 1'b1;
    if (done) begin
      done_cyc  = cyc;
      done_busy = busy;
      done_csum = csum;
    end
  end

  task automatic launch(input logic [SAW-1:0] s, input logic [DAW-1:0] d, input logic [LW-1:0] l);
    logic [SAW-1:0] ra;
    logic [DAW-1:0] wa;
    @(negedge clk);
    exp_csum = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      ra = s + SAW'(i);
      wa = d + DAW'(i);
      rd_q.push_back(ra);
      wr_q.push_back({wa, mem[ra]});
      exp_csum = exp_csum ^ mem[ra];
    end
    rd_count = 0; wr_count = 0; first_rd = -1; done_cyc = -1; hold_seen = 1'b0;
    start = 1'b1; src_base = s; dst_base = d; len = l; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic grant(output int h);
    for (int i = 0; i < 20; i++) begin
      if (hold) break;
      @(negedge clk);
    end
    chk("hold_up", hold, 1'b1);
    chk("hold_latency", cyc, start_cyc + 1);
    h = cyc;
    hlda = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cyc >= 0) break;
    end
    chk("done_seen", done_cyc >= 0, 1'b1);
    chk("done_busy", done_busy, 1'b1);
    chk("done_csum", done_csum, CSUM_ON ? exp_csum : 8'h00);
    hlda = 1'b0;
    @(negedge clk); #1;
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("idle_hold", hold, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("csum_stable", csum, CSUM_ON ? exp_csum : 8'h00);
  endtask

  function automatic logic [63:0] all_outs();
    return {23'd0, hold, src_addr, src_ce, dst_addr, dst_d, dst_ce, dst_we, busy, done, csum};
  endfunction

  initial begin
    int h;
    bit found;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;

    // Basic object-block copy
    launch(10'h100, 9'h000, LW'(OBJ_LEN));
    grant(h);
    wait_done(600);
    chk("basic_first_rd", first_rd, h + 1);
    chk("basic_done_cyc", done_cyc, h + OBJ_LEN + 2);
    chk("basic_wr_count", wr_count, OBJ_LEN);

    // Zero length
    launch(10'h055, 9'h010, 9'd0);
    wait_done(10);
    chk("zero_done_cyc", done_cyc, start_cyc + 1);
    chk("zero_no_hold", hold_seen, 1'b0);
    chk("zero_no_rd", rd_count, 0);
    chk("zero_no_wr", wr_count, 0);

    // HLDA stall after byte 10 is read
    launch(10'h020, 9'h080, 9'd32);
    grant(h);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (src_ce && src_addr == 10'h02A) begin found = 1'b1; break; end
    end
    chk("stall_found_rd10", found, 1'b1);
    hlda = 1'b0;
    repeat (5) @(negedge clk);
    hlda = 1'b1;
    wait_done(200);
    chk("stall_rd_count", rd_count, 32);
    chk("stall_wr_count", wr_count, 32);

    // Address wrap on both sides
    launch(10'h3FE, 9'h1FF, 9'd4);
    grant(h);
    wait_done(50);
    chk("wrap_done_cyc", done_cyc, h + 6);

    // Reset mid-transfer after 20 writes
    launch(10'h000, 9'h040, LW'(OBJ_LEN));
    grant(h);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (wr_count >= 20) break;
    end
    chk("rst_mid_wr20", wr_count, 20);
    rst = 1'b1; hlda = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    chk("rst_mid_outs", all_outs(), 64'd0);

    // Fresh start, with a second start pulse while busy
    launch(10'h180, 9'h100, 9'd40);
    grant(h);
    repeat (10) @(negedge clk);
    start = 1'b1; src_base = 10'h300; dst_base = 9'h000; len = 9'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    chk("restart_done_cyc", done_cyc, h + 42);
    chk("restart_wr_count", wr_count, 40);

    // Checksum pattern
    mem[10'h200] = 8'h01; mem[10'h201] = 8'h02; mem[10'h202] = 8'h04; mem[10'h203] = 8'h80;
    launch(10'h200, 9'h000, 9'd4);
    grant(h);
    wait_done(50);
    chk("csum_pattern", done_csum, CSUM_ON ? 8'h87 : 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
